// File: rtl/multi_port_memory_unit.sv
// multi_port_memory_unit
// ----------------------
// Runs one core memory access cycle across NumPorts independent channels
// (for example inst fetch, data, CSR-mapped space, DMA). When a cycle
// starts, every requested channel is strobed in parallel. A pending mask
// tracks which channels have not yet acknowledged. Read data is either
// bypassed to the core in the ack cycle or held in a per-channel buffer.
// The core is stalled (busy) until every requested channel has acked.
//
// Parameters:
//   Width         data width of every channel
//   NumPorts      number of memory channels (>= 1)
//   AlwaysMask    channels requested on every transaction (bit0 = inst fetch)
//   TimeoutCycles max cycles spent in Wait before abort (>= 2, timeout build only)
//
// Optional feature macro: MEMORY_UNIT_TIMEOUT_EN
//   defined   -> a Wait-cycle counter aborts a stuck transaction and pulses
//                timeout_err
//   undefined -> no counter, timeout_err tied low, Wait lasts until all acks
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   rd_mem       per-channel read request
//   wr_mem       per-channel write request (wins over rd_mem on one channel)
//   mem_ack      per-channel ack from memory
//   mem_rd_dat   per-channel read data, valid with ack
//   mem_en       per-channel enable/strobe
//   mem_we       per-channel write enable
//   mem_dat      per-channel data to core (same-cycle bypass or buffered)
//   busy         stall core while high
//   timeout_err  one-cycle pulse on an aborted transaction
module multi_port_memory_unit #(
  parameter int                     Width         = 32,
  parameter int                     NumPorts      = 2,
  parameter logic [NumPorts-1:0]    AlwaysMask    = NumPorts'(1),
  parameter int                     TimeoutCycles = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NumPorts-1:0]                rd_mem,
  input  logic [NumPorts-1:0]                wr_mem,
  input  logic [NumPorts-1:0]                mem_ack,
  input  logic [NumPorts-1:0][Width-1:0]     mem_rd_dat,
  output logic [NumPorts-1:0]                mem_en,
  output logic [NumPorts-1:0]                mem_we,
  output logic [NumPorts-1:0][Width-1:0]     mem_dat,
  output logic                               busy,
  output logic                               timeout_err
);

  // Elaboration-time sanity checks on the configuration.
  if (NumPorts < 1) begin : g_bad_ports
    $error("multi_port_memory_unit: NumPorts must be >= 1");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("multi_port_memory_unit: TimeoutCycles must be >= 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                          state;
  state_e                          next_state;
  logic [NumPorts-1:0]             pending;
  logic [NumPorts-1:0]             next_pending;
  logic [NumPorts-1:0]             req;
  logic [NumPorts-1:0]             remaining;
  logic [NumPorts-1:0]             hit;
  logic [NumPorts-1:0][Width-1:0]  rd_buf;
  logic                            abort;

  // The timeout condition comes from the Wait-cycle counter when the
  // feature is built in. Otherwise it is a constant zero and Wait only
  // ends on completion.
`ifdef MEMORY_UNIT_TIMEOUT_EN
  localparam int                 CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0]    CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] wait_cnt;

  // Counter is held at zero in Idle, so it starts at 0 in the first Wait
  // cycle. It never needs to saturate: Wait is abandoned at CntLast.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign abort = (state == ST_WAIT) && (wait_cnt == CntLast) && (remaining != '0);
`else
  assign abort = 1'b0;
`endif

  assign timeout_err = abort;

  // State and pending-mask register. A reset at any point, including
  // mid-Wait, drops the transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
    end
  end

  // Next-state and output decode. In Idle the requests drive the strobes
  // directly. In Wait only the channels still owing an ack stay strobed.
  // A completion in the same cycle as the timeout wins, because abort
  // requires remaining != 0.
  always_comb begin
    req          = AlwaysMask | rd_mem | wr_mem;
    remaining    = pending & ~mem_ack;
    next_state   = state;
    next_pending = pending;
    mem_en       = '0;
    mem_we       = '0;
    busy         = 1'b0;
    hit          = '0;

    unique case (state)
      ST_IDLE: begin
        mem_en = req;
        mem_we = wr_mem & req;
        busy   = (req != '0);
        if (req != '0) begin
          next_state   = ST_WAIT;
          next_pending = req;
        end
      end

      ST_WAIT: begin
        mem_en = pending;
        mem_we = pending & wr_mem;
        hit    = pending & mem_ack;
        if (remaining == '0) begin
          next_state   = ST_IDLE;
          next_pending = '0;
        end else if (abort) begin
          next_state   = ST_IDLE;
          next_pending = '0;
        end else begin
          busy         = 1'b1;
          next_pending = remaining;
        end
      end

      default: begin
        next_state   = ST_IDLE;
        next_pending = '0;
      end
    endcase
  end

  // Read buffers capture data only from a channel that is still pending
  // and acks during Wait. Stray acks never disturb them.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_buf <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (hit[i]) begin
          rd_buf[i] <= mem_rd_dat[i];
        end
      end
    end
  end

  // Same-cycle bypass, so the core can use the data in the cycle busy drops.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      mem_dat[i] = hit[i] ? mem_rd_dat[i] : rd_buf[i];
    end
  end

endmodule

// File: tb/tb_multi_port_memory_unit.sv
// tb_multi_port_memory_unit
// -------------------------
// Transaction-level reference. Each transaction is described by its
// requests and by the Wait cycle in which each requested channel acks.
// Per-cycle expectations are derived from those delays and queued. A
// separate monitor pops one expectation per cycle on the falling edge and
// compares it with the DUT outputs.
module tb_multi_port_memory_unit;

  localparam int            W  = 32;
  localparam int            NP = 3;
  localparam int            TO = 6;
  localparam logic [NP-1:0] AM = 3'b001;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NP-1:0]          rd_mem, wr_mem, mem_ack, mem_en, mem_we;
  logic [NP-1:0][W-1:0]   mem_rd_dat, mem_dat;
  logic                   busy, timeout_err;

  always #5 clock = ~clock;

  multi_port_memory_unit #(
    .Width(W), .NumPorts(NP), .AlwaysMask(AM), .TimeoutCycles(TO)
  ) dut (
    .clock(clock), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .mem_ack(mem_ack), .mem_rd_dat(mem_rd_dat), .mem_en(mem_en),
    .mem_we(mem_we), .mem_dat(mem_dat), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [NP-1:0]        en;
    logic [NP-1:0]        we;
    logic                 bsy;
    logic                 terr;
    logic [NP-1:0][W-1:0] dat;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 mon_e;
  logic [NP-1:0][W-1:0] model_buf;
  int                   dly [NP];
  int                   total = 0;
  int                   bad   = 0;

  // Compare one cycle's expectation against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    total++;
    if (mem_en !== e.en) begin
      bad++;
      $display("[TB] FAIL mem_en: got %b expected %b", mem_en, e.en);
    end
    total++;
    if (mem_we !== e.we) begin
      bad++;
      $display("[TB] FAIL mem_we: got %b expected %b", mem_we, e.we);
    end
    total++;
    if (busy !== e.bsy) begin
      bad++;
      $display("[TB] FAIL busy: got %b expected %b", busy, e.bsy);
    end
    total++;
    if (timeout_err !== e.terr) begin
      bad++;
      $display("[TB] FAIL timeout_err: got %b expected %b", timeout_err, e.terr);
    end
    for (int i = 0; i < NP; i++) begin
      total++;
      if (mem_dat[i] !== e.dat[i]) begin
        bad++;
        $display("[TB] FAIL mem_dat[%0d]: got %h expected %h", i, mem_dat[i], e.dat[i]);
      end
    end
  endtask

  // Monitor: one expectation is queued per driven cycle, popped mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  // Drive one transaction. The Idle cycle is followed by Wait cycles
  // 1..end. Channel i acks in Wait cycle dly[i]. Idle and non-pending
  // channels get random stray acks. rst_at > 0 asserts reset in that Wait
  // cycle, provided the transaction is still open then.
  task automatic applyStimulus(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                               input int rst_at);
    logic [NP-1:0] req;
    int            last;
    int            endc;
    bit            tmo;
    bit            pend;
    exp_t          e;
    req  = AM | rd | wr;
    last = 0;
    for (int i = 0; i < NP; i++)
      if (req[i] && dly[i] > last) last = dly[i];
    endc = last;
    tmo  = 1'b0;
`ifdef MEMORY_UNIT_TIMEOUT_EN
    if (last > TO) begin
      endc = TO;
      tmo  = 1'b1;
    end
`endif
    @(posedge clock); #1;
    reset   = 1'b0;
    rd_mem  = rd;
    wr_mem  = wr;
    mem_ack = NP'($urandom);
    for (int i = 0; i < NP; i++) mem_rd_dat[i] = $urandom;
    e.en   = req;
    e.we   = wr & req;
    e.bsy  = 1'b1;
    e.terr = 1'b0;
    e.dat  = model_buf;
    exp_q.push_back(e);

    for (int k = 1; k <= endc; k++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NP; i++) begin
        mem_rd_dat[i] = $urandom;
        pend     = req[i] && (dly[i] >= k);
        e.en[i]  = pend;
        e.we[i]  = pend & wr[i];
        e.dat[i] = model_buf[i];
        if (pend) begin
          mem_ack[i] = (dly[i] == k) && !(k == rst_at && k < endc);
          if (mem_ack[i]) e.dat[i] = mem_rd_dat[i];
        end else begin
          mem_ack[i] = 1'($urandom);
        end
      end
      e.bsy  = (k < endc);
      e.terr = (k == endc) && tmo;
      exp_q.push_back(e);
      if (k == rst_at && k < endc) begin
        reset     = 1'b1;
        model_buf = '0;
        return;
      end
      for (int i = 0; i < NP; i++)
        if (req[i] && mem_ack[i] && dly[i] == k) model_buf[i] = mem_rd_dat[i];
    end
  endtask

  initial begin
    reset      = 1'b1;
    rd_mem     = '0;
    wr_mem     = '0;
    mem_ack    = '0;
    mem_rd_dat = '0;
    model_buf  = '0;
    repeat (2) @(posedge clock);

    // Read on ch1, both acks in the first Wait cycle.
    dly = '{1, 1, 1};
    applyStimulus(3'b010, 3'b000, 0);
    // Write on ch2: ch0 acks in cycle 1, ch2 in cycle 3.
    dly = '{1, 1, 3};
    applyStimulus(3'b000, 3'b100, 0);
    // Read and write together on ch1 act as a write.
    dly = '{2, 1, 1};
    applyStimulus(3'b010, 3'b010, 0);
    // Reset mid-Wait with ch1 still pending.
    dly = '{1, 4, 1};
    applyStimulus(3'b010, 3'b000, 2);
    // Ack arriving exactly in the last allowed cycle, then a stuck channel.
    dly = '{1, TO, 1};
    applyStimulus(3'b010, 3'b000, 0);
    dly = '{1, TO + 3, 1};
    applyStimulus(3'b010, 3'b000, 0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NP; i++)
        dly[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(1, 4);
      applyStimulus(NP'($urandom), NP'($urandom),
                    ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    // A final Idle cycle exposes the buffered data.
    dly = '{1, 1, 1};
    applyStimulus(3'b000, 3'b000, 0);
    repeat (3) @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
